// File: rtl/neu_pkg.sv
// neu_pkg: shared constants and helpers for the grid-node cost relaxer.
// Compass codes, step costs and index-to-direction mapping.
package neu_pkg;

  localparam logic [1:0] PERP = 2'd2;
  localparam logic [1:0] DIAG = 2'd3;

  typedef enum logic [2:0] {
    DIR_N,
    DIR_NE,
    DIR_E,
    DIR_SE,
    DIR_S,
    DIR_SW,
    DIR_W,
    DIR_NW
  } dir_e;

  function automatic logic [2:0] compass(
    input int         conn,
    input logic [2:0] idx
  );
    return (conn == 8) ? idx : {idx[1:0], 1'b0};
  endfunction

  function automatic logic is_diag(
    input int         conn,
    input logic [2:0] idx
  );
    return (conn == 8) && idx[0];
  endfunction

endpackage

// File: rtl/neu_v2_if.sv
// neu_v2_if: command, neighbour and result bundle of one grid node.
// master = controller side, slave = node side.
interface neu_v2_if #(
  parameter int COST_W   = 12,
  parameter int WEIGHT_W = 4,
  parameter int CONN     = 8
);

  logic                     clr;
  logic                     inv;
  logic                     ld;
  logic [WEIGHT_W-1:0]      ld_weight;
  logic                     en;
  logic [CONN*COST_W-1:0]   nbr_cost;
  logic                     path_mod;
  logic [COST_W-1:0]        path_cost;
  logic [2:0]               path_dir;
  logic                     stable;

  modport master (
    output clr, inv, ld, ld_weight, en, nbr_cost,
    input  path_mod, path_cost, path_dir, stable
  );

  modport slave (
    input  clr, inv, ld, ld_weight, en, nbr_cost,
    output path_mod, path_cost, path_dir, stable
  );

endinterface

// File: rtl/neu_travel.sv
// neu_travel: neighbour select, travel cost and improvement compare.
// Purely combinational; the sum is kept wide so it can never wrap.
module neu_travel
  import neu_pkg::*;
#(
  parameter int COST_W   = 12,
  parameter int WEIGHT_W = 4,
  parameter int CONN     = 8
) (
  input  logic [CONN*COST_W-1:0] nbr_cost,
  input  logic [2:0]             idx,
  input  logic [WEIGHT_W-1:0]    weight,
  input  logic [COST_W-1:0]      cost,
  output logic                   improve,
  output logic [COST_W-1:0]      travel
);

  localparam int TW = COST_W + WEIGHT_W + 2;
  localparam logic [COST_W-1:0] MAX = '1;

  logic [COST_W-1:0] adj;
  logic [1:0]        step;
  logic [TW-1:0]     wide;
  logic              reject;

  // pick the neighbour addressed by idx
  always_comb begin
    adj = MAX;
    for (int i = 0; i < CONN; i++) begin
      if (idx == 3'(i)) adj = nbr_cost[i*COST_W +: COST_W];
    end
  end

  // travel sum, reject unreachable or saturating candidates, compare
  always_comb begin
    step    = is_diag(CONN, idx) ? DIAG : PERP;
    wide    = TW'(adj) + (TW'(weight) << 1) + TW'(step);
    reject  = (adj == MAX) || (wide >= TW'(MAX));
    improve = !reject && (wide < TW'(cost));
    travel  = wide[COST_W-1:0];
  end

endmodule

// File: rtl/neu_v2.sv
// neu_v2: one grid node of a wavefront shortest-path relaxer.
// Sweeps its neighbours one per cycle, keeping the cheapest path.
module neu_v2
  import neu_pkg::*;
#(
  parameter int X        = 0,
  parameter int Y        = 0,
  parameter int COST_W   = 12,
  parameter int WEIGHT_W = 4,
  parameter int CONN     = 8
) (
  input logic      clk,
  input logic      rst_n,
  neu_v2_if.slave  bus
);

  localparam logic [COST_W-1:0]   MAX     = '1;
  localparam logic [WEIGHT_W-1:0] BLOCKED = '1;
  localparam logic [3:0]          FULL    = 4'(CONN);
  localparam logic [2:0]          LAST    = 3'(CONN - 1);

  if (X < 0 || Y < 0 || !(CONN == 4 || CONN == 8) ||
      COST_W < 8 || COST_W > 16) begin : g_bad_cfg
    $error("neu_v2 (%0d,%0d): illegal CONN/COST_W", X, Y);
  end

  logic [COST_W-1:0]   cost, cost_n;
  logic [2:0]          dir, dir_n;
  logic [WEIGHT_W-1:0] weight, weight_n;
  logic [2:0]          idx, idx_n;
  logic [3:0]          cnt, cnt_n;
  logic                stable, stable_n;

  logic                accessible;
  logic                do_clr, do_inv, do_ld, do_eval;
  logic                improve;
  logic [COST_W-1:0]   travel;

  neu_travel #(
    .COST_W   (COST_W),
    .WEIGHT_W (WEIGHT_W),
    .CONN     (CONN)
  ) u_travel (
    .nbr_cost (bus.nbr_cost),
    .idx      (idx),
    .weight   (weight),
    .cost     (cost),
    .improve  (improve),
    .travel   (travel)
  );

  // one-hot command decode in priority order clr > inv > ld > eval
  always_comb begin
    accessible = (weight != BLOCKED);
    do_clr     = bus.clr;
    do_inv     = bus.inv & ~bus.clr;
    do_ld      = bus.ld & ~bus.inv & ~bus.clr;
    do_eval    = bus.en & ~bus.ld & ~bus.inv & ~bus.clr & accessible;
  end

  // next-state for cost, direction, weight, index and stability count
  always_comb begin
    cost_n   = cost;
    dir_n    = dir;
    weight_n = weight;
    idx_n    = idx;
    cnt_n    = cnt;
    unique case (1'b1)
      do_clr: begin
        cost_n = '0;
        dir_n  = DIR_N;
        idx_n  = '0;
        cnt_n  = '0;
      end
      do_inv: begin
        cost_n = MAX;
        dir_n  = DIR_N;
        idx_n  = '0;
        cnt_n  = '0;
      end
      do_ld: begin
        weight_n = bus.ld_weight;
        cnt_n    = '0;
      end
      do_eval: begin
        idx_n = (idx == LAST) ? 3'd0 : idx + 3'd1;
        if (improve) begin
          cost_n = travel;
          dir_n  = compass(CONN, idx);
          cnt_n  = '0;
        end else if (cnt != FULL) begin
          cnt_n = cnt + 4'd1;
        end
      end
      default: ;
    endcase
    stable_n = (weight_n == BLOCKED) || (cnt_n == FULL);
  end

  // state registers; reset leaves the node blocked and unreachable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cost   <= MAX;
      dir    <= DIR_N;
      weight <= BLOCKED;
      idx    <= '0;
      cnt    <= '0;
      stable <= 1'b1;
    end else begin
      cost   <= cost_n;
      dir    <= dir_n;
      weight <= weight_n;
      idx    <= idx_n;
      cnt    <= cnt_n;
      stable <= stable_n;
    end
  end

  assign bus.path_mod  = do_eval & improve;
  assign bus.path_cost = cost;
  assign bus.path_dir  = dir;
  assign bus.stable    = stable;

endmodule

// File: tb/tb_neu_v2.sv
// tb_neu_v2: directed checks of neu_v2 in 8-conn, 8-bit-cost
// and 4-conn configurations.
module tb_neu_v2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  neu_v2_if #(.COST_W(12), .WEIGHT_W(4), .CONN(8)) ia ();
  neu_v2_if #(.COST_W(8),  .WEIGHT_W(4), .CONN(8)) ib ();
  neu_v2_if #(.COST_W(12), .WEIGHT_W(4), .CONN(4)) ic ();

  neu_v2 #(.X(1), .Y(2), .COST_W(12), .WEIGHT_W(4), .CONN(8))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  neu_v2 #(.X(3), .Y(4), .COST_W(8), .WEIGHT_W(4), .CONN(8))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));
  neu_v2 #(.X(5), .Y(6), .COST_W(12), .WEIGHT_W(4), .CONN(4))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(ic));

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    checks++;
    if (ia.path_cost !== 12'd4095) begin
      failures++;
      $display("FAIL reset_cost_a got=%0d exp=4095", ia.path_cost);
    end
    checks++;
    if (ia.path_dir !== 3'd0 || ia.stable !== 1'b1) begin
      failures++;
      $display("FAIL reset_dir_stable_a got=%0d/%0b exp=0/1",
               ia.path_dir, ia.stable);
    end
    checks++;
    if (ib.path_cost !== 8'd255) begin
      failures++;
      $display("FAIL reset_cost_b got=%0d exp=255", ib.path_cost);
    end
    checks++;
    if (ic.stable !== 1'b1 || ic.path_cost !== 12'd4095) begin
      failures++;
      $display("FAIL reset_c got=%0b/%0d exp=1/4095",
               ic.stable, ic.path_cost);
    end
  endtask

  task automatic test_source();
    ia.ld = 1'b1; ia.ld_weight = 4'd1;
    tick();
    ia.ld = 1'b0; ia.clr = 1'b1;
    tick();
    ia.clr = 1'b0;
    checks++;
    if (ia.path_cost !== 12'd0 || ia.stable !== 1'b0) begin
      failures++;
      $display("FAIL src_clr got=%0d/%0b exp=0/0",
               ia.path_cost, ia.stable);
    end
    ia.nbr_cost = '0;
    ia.en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if (ia.path_mod !== 1'b0) begin
        failures++;
        $display("FAIL src_mod[%0d] got=%0b exp=0", i, ia.path_mod);
      end
      tick();
      if (i == 6) begin
        checks++;
        if (ia.stable !== 1'b0) begin
          failures++;
          $display("FAIL src_stable7 got=%0b exp=0", ia.stable);
        end
      end
    end
    ia.en = 1'b0;
    checks++;
    if (ia.stable !== 1'b1 || ia.path_cost !== 12'd0) begin
      failures++;
      $display("FAIL src_stable8 got=%0b/%0d exp=1/0",
               ia.stable, ia.path_cost);
    end
  endtask

  task automatic test_relax();
    int pulses;
    pulses = 0;
    ia.ld = 1'b1; ia.ld_weight = 4'd2;
    tick();
    ia.ld = 1'b0; ia.inv = 1'b1;
    tick();
    ia.inv = 1'b0;
    ia.nbr_cost = '1;
    ia.nbr_cost[2*12 +: 12] = 12'd10;
    ia.en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      if (ia.path_mod === 1'b1) pulses++;
      checks++;
      if (ia.path_mod !== (i == 2)) begin
        failures++;
        $display("FAIL relax_mod[%0d] got=%0b exp=%0b",
                 i, ia.path_mod, (i == 2));
      end
      tick();
    end
    ia.en = 1'b0;
    checks++;
    if (ia.path_cost !== 12'd16 || ia.path_dir !== 3'd2) begin
      failures++;
      $display("FAIL relax_result got=%0d/%0d exp=16/2",
               ia.path_cost, ia.path_dir);
    end
    checks++;
    if (pulses != 1 || ia.stable !== 1'b1) begin
      failures++;
      $display("FAIL relax_pulses got=%0d/%0b exp=1/1",
               pulses, ia.stable);
    end
    tick();
    tick();
    checks++;
    if (ia.path_cost !== 12'd16 || ia.stable !== 1'b1) begin
      failures++;
      $display("FAIL relax_hold got=%0d/%0b exp=16/1",
               ia.path_cost, ia.stable);
    end
    ia.inv = 1'b1;
    tick();
    ia.inv = 1'b0;
    checks++;
    if (ia.path_cost !== 12'd4095 || ia.stable !== 1'b0) begin
      failures++;
      $display("FAIL relax_inv got=%0d/%0b exp=4095/0",
               ia.path_cost, ia.stable);
    end
    ia.en = 1'b1;
    repeat (8) tick();
    ia.en = 1'b0;
    checks++;
    if (ia.path_cost !== 12'd16 || ia.path_dir !== 3'd2) begin
      failures++;
      $display("FAIL relax_reval got=%0d/%0d exp=16/2",
               ia.path_cost, ia.path_dir);
    end
  endtask

  task automatic test_diag_tie();
    ia.ld = 1'b1; ia.ld_weight = 4'd0;
    tick();
    ia.ld = 1'b0; ia.inv = 1'b1;
    tick();
    ia.inv = 1'b0;
    ia.nbr_cost = '1;
    ia.nbr_cost[1*12 +: 12] = 12'd5;
    ia.nbr_cost[2*12 +: 12] = 12'd6;
    ia.en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if (ia.path_mod !== (i == 1)) begin
        failures++;
        $display("FAIL tie_mod[%0d] got=%0b exp=%0b",
                 i, ia.path_mod, (i == 1));
      end
      tick();
    end
    checks++;
    if (ia.path_cost !== 12'd8 || ia.path_dir !== 3'd1) begin
      failures++;
      $display("FAIL tie_keep got=%0d/%0d exp=8/1",
               ia.path_cost, ia.path_dir);
    end
    ia.nbr_cost[2*12 +: 12] = 12'd5;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if (ia.path_mod !== (i == 2)) begin
        failures++;
        $display("FAIL diag_mod[%0d] got=%0b exp=%0b",
                 i, ia.path_mod, (i == 2));
      end
      tick();
    end
    ia.en = 1'b0;
    checks++;
    if (ia.path_cost !== 12'd7 || ia.path_dir !== 3'd2) begin
      failures++;
      $display("FAIL diag_better got=%0d/%0d exp=7/2",
               ia.path_cost, ia.path_dir);
    end
  endtask

  task automatic test_saturation();
    int mods;
    mods = 0;
    ib.ld = 1'b1; ib.ld_weight = 4'd14;
    tick();
    ib.ld = 1'b0;
    ib.nbr_cost = {8{8'd250}};
    ib.en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (ib.path_mod !== 1'b0) mods++;
      tick();
    end
    checks++;
    if (mods != 0 || ib.path_cost !== 8'd255) begin
      failures++;
      $display("FAIL sat_reject got=%0d/%0d exp=0/255",
               mods, ib.path_cost);
    end
    ib.en = 1'b0;
    ib.ld = 1'b1; ib.ld_weight = 4'd0;
    tick();
    ib.ld = 1'b0;
    ib.nbr_cost = '1;
    ib.nbr_cost[7:0] = 8'd253;
    ib.en = 1'b1;
    repeat (8) tick();
    checks++;
    if (ib.path_cost !== 8'd255) begin
      failures++;
      $display("FAIL sat_edge253 got=%0d exp=255", ib.path_cost);
    end
    ib.nbr_cost[7:0] = 8'd252;
    #1;
    checks++;
    if (ib.path_mod !== 1'b1) begin
      failures++;
      $display("FAIL sat_edge252_mod got=%0b exp=1", ib.path_mod);
    end
    tick();
    ib.en = 1'b0;
    checks++;
    if (ib.path_cost !== 8'd254 || ib.path_dir !== 3'd0) begin
      failures++;
      $display("FAIL sat_edge252 got=%0d/%0d exp=254/0",
               ib.path_cost, ib.path_dir);
    end
  endtask

  task automatic test_four_conn();
    ic.ld = 1'b1; ic.ld_weight = 4'd0;
    tick();
    ic.ld = 1'b0;
    ic.nbr_cost = '1;
    ic.nbr_cost[3*12 +: 12] = 12'd20;
    ic.en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (ic.path_mod !== (i == 3)) begin
        failures++;
        $display("FAIL c4_mod[%0d] got=%0b exp=%0b",
                 i, ic.path_mod, (i == 3));
      end
      tick();
    end
    checks++;
    if (ic.path_cost !== 12'd22 || ic.path_dir !== 3'd6) begin
      failures++;
      $display("FAIL c4_west got=%0d/%0d exp=22/6",
               ic.path_cost, ic.path_dir);
    end
    ic.nbr_cost[11:0] = 12'd5;
    #1;
    checks++;
    if (ic.path_mod !== 1'b1) begin
      failures++;
      $display("FAIL c4_wrap_mod got=%0b exp=1", ic.path_mod);
    end
    tick();
    ic.en = 1'b0;
    checks++;
    if (ic.path_cost !== 12'd7 || ic.path_dir !== 3'd0) begin
      failures++;
      $display("FAIL c4_wrap got=%0d/%0d exp=7/0",
               ic.path_cost, ic.path_dir);
    end
  endtask

  task automatic test_priority_reset();
    ia.clr = 1'b1; ia.inv = 1'b1;
    ia.ld = 1'b1; ia.ld_weight = 4'd15;
    tick();
    ia.clr = 1'b0; ia.inv = 1'b0; ia.ld = 1'b0;
    checks++;
    if (ia.path_cost !== 12'd0 || ia.path_dir !== 3'd0 ||
        ia.stable !== 1'b0) begin
      failures++;
      $display("FAIL prio_clr got=%0d/%0d/%0b exp=0/0/0",
               ia.path_cost, ia.path_dir, ia.stable);
    end
    ia.nbr_cost = '0;
    ia.en = 1'b1;
    repeat (3) tick();
    ia.en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ia.path_cost !== 12'd4095 || ia.path_dir !== 3'd0 ||
        ia.stable !== 1'b1) begin
      failures++;
      $display("FAIL async_rst got=%0d/%0d/%0b exp=4095/0/1",
               ia.path_cost, ia.path_dir, ia.stable);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ia.en = 1'b1;
    #1;
    checks++;
    if (ia.path_mod !== 1'b0) begin
      failures++;
      $display("FAIL rst_blocked_mod got=%0b exp=0", ia.path_mod);
    end
    tick();
    ia.en = 1'b0;
    checks++;
    if (ia.path_cost !== 12'd4095 || ia.stable !== 1'b1) begin
      failures++;
      $display("FAIL rst_blocked got=%0d/%0b exp=4095/1",
               ia.path_cost, ia.stable);
    end
  endtask

  initial begin
    ia.clr = 0; ia.inv = 0; ia.ld = 0; ia.ld_weight = '0;
    ia.en = 0; ia.nbr_cost = '0;
    ib.clr = 0; ib.inv = 0; ib.ld = 0; ib.ld_weight = '0;
    ib.en = 0; ib.nbr_cost = '0;
    ic.clr = 0; ic.inv = 0; ic.ld = 0; ic.ld_weight = '0;
    ic.en = 0; ic.nbr_cost = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_source();
    test_relax();
    test_diag_tie();
    test_saturation();
    test_four_conn();
    test_priority_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
